// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared glyph constants and anode helper for the seven-segment scan driver.
// All segment codes are active-low, bit 6 = a ... bit 0 = g.
package seven_seg_scan_driver_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_0     = 7'h01;
  localparam seg7_t SEG_1     = 7'h4F;
  localparam seg7_t SEG_2     = 7'h12;
  localparam seg7_t SEG_3     = 7'h06;
  localparam seg7_t SEG_4     = 7'h4C;
  localparam seg7_t SEG_5     = 7'h24;
  localparam seg7_t SEG_6     = 7'h20;
  localparam seg7_t SEG_7     = 7'h0F;
  localparam seg7_t SEG_8     = 7'h00;
  localparam seg7_t SEG_9     = 7'h04;
  localparam seg7_t SEG_A     = 7'h08;
  localparam seg7_t SEG_B     = 7'h60;
  localparam seg7_t SEG_C     = 7'h31;
  localparam seg7_t SEG_D     = 7'h42;
  localparam seg7_t SEG_E     = 7'h30;
  localparam seg7_t SEG_F     = 7'h38;

  // Active-low anode k: off unless it is the scanned digit and that digit is lit.
  function automatic logic an_off(input int k, input logic [2:0] idx, input logic lit);
    return !(lit && (k == int'(idx)));
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg7_t      seg_o
);

  always_comb begin
    case (hex_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with blank gaps,
// leading-zero suppression and frame-synchronous (tear-free) display updates.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYC);

  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    tick_pend_q, tick_pend_d;
  seg7_t                   seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_end, wrap, lit;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              nibble;
  seg7_t                   glyph;

  assign slot_end = (pcnt_q == PCNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);

  // A digit is suppressed when it and every digit above it read zero; digit 0 never is.
  always_comb begin : lz_mask_comb
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (act_digits_q[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_en & zero_run;
    end
  end

  assign nibble = act_digits_q[4*idx_q +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pcnt_d        = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d         = idx_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    tick_pend_d   = wrap;

    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_blank_d  = blank_in;
      pend_valid_d  = 1'b1;
    end

    // A load landing on the wrap cycle bypasses the pending bank.
    if (wrap) begin
      if (load) begin
        act_digits_d = digits_in;
        act_dp_d     = dp_in;
        act_blank_d  = blank_in;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end

    lit          = (pcnt_q >= BLANK_END) && !act_blank_q[idx_q] && !lz_mask[idx_q];
    seg_d        = lit ? glyph : SEG_BLANK;
    dp_d         = !(lit && act_dp_q[idx_q]);
    frame_tick_d = tick_pend_q;
    an_d         = '1;
    for (int k = 0; k < NUM_DIGITS; k++) an_d[k] = an_off(k, 3'(idx_q), lit);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      // NOTE: the digit banks are a handful of flops, so they reset with everything else.
      pcnt_q        <= '0;
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      tick_pend_q   <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      tick_pend_q   <= tick_pend_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits, such as the Basys3 4-digit display. It takes a packed vector of 4-bit hex values and scans one digit at a time. It supports per-digit decimal points and blanking, optional leading-zero suppression, anti-ghosting blank gaps and tear-free frame-synchronous updates. It sits between the application datapath and the board pins, and generalises the team's single-digit hex decoder to N digits with its own scan timing.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 100000: clocks per digit slot (1 ms at 100 MHz); must exceed BLANK_CYC.
- BLANK_CYC, 1000: clocks at slot start with all anodes off (≥1).
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous and active-low.
- load  in  1  strobe: capture digits_in/dp_in/blank_in into pending registers.
- digits_in  in  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit dark.
- lz_en  in  1  leading-zero suppression enable (sampled live).
- seg  out  7  segments a..g, bit 6 = a … bit 0 = g, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while a digit is lit.
- frame_tick  out  1  one-cycle pulse when scan wraps to digit 0.

## Operation
- Glyphs (seg hex, active-low): 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38.
- Prescaler `pcnt` counts 0..SCAN_DIV-1. At terminal count, `idx` advances and wraps NUM_DIGITS-1 → 0.
- While pcnt < BLANK_CYC: an, seg and dp are all 1.
- Otherwise an[idx] = 0 and seg/dp show active digit idx. The digit is dark if active blank[idx] is set or it is leading-zero suppressed.
- Leading-zero suppression (lz_en=1): digit k is suppressed when its nibble and every higher digit's nibble are 0, k ≥ 1. Digit 0 is never suppressed. A suppressed or blanked digit also has dp dark.
- Update path: load=1 copies the inputs to pending registers and sets `pend_valid`. When idx wraps to 0, pending copies to active if pend_valid, then pend_valid clears.
- load in the same cycle as the wrap: the new input values become active at that wrap, and pend_valid ends 0.
- Repeated loads before a wrap: the last one wins.

## Timing
- Reset (reset_n=0 at a clk edge): pcnt=0, idx=0, pend_valid=0.
- Active and pending: digits=0, dp=0, blank all 1s.
- Registered outputs: an all 1s, seg=7'h7F, dp=1, frame_tick=0.
- Reset mid-frame aborts the scan immediately (next edge). A pending load is discarded.
- All outputs are registered. Pins reflect pcnt/idx/active state with exactly 1 clk latency.
- Digit k is lit for SCAN_DIV-BLANK_CYC cycles per slot. The frame period is NUM_DIGITS*SCAN_DIV cycles.
- frame_tick is high for 1 cycle, coincident with the first (blank) output cycle of digit 0.
- After reset release, the first lit cycle of digit 0 appears on pins BLANK_CYC+1 cycles later. All digits blanked until first load.
- A load becomes visible on pins at the first digit-0 lit cycle after the next wrap, never mid-frame.
- lz_en changes take effect within the current slot (combinational into output register).

## Structure
- Shared package: glyph constants (SEG_BLANK=7'h7F and the 16 hex codes) and an `an_off` helper function.
- Sub-module `hex_to_seg7`: combinational 4-bit → 7-bit active-low decoder using the glyph table above, instantiated once on the muxed nibble.
- Top: prescaler, index counter, pending/active register banks, LZ-suppression mask logic, output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset: hold reset_n=0 for 3 cycles → an=4'hF, seg=7'h7F, dp=1, frame_tick=0. After release, all digits stay dark (no load).
- Scan: load digits_in=16'h1A3F, blank 0, dp 0 → after wrap, per frame: an=1110 seg=38, an=1101 seg=06, an=1011 seg=08, an=0111 seg=4F. Each lit 6 cycles, preceded by 2 cycles an=1111. Frame = 32 cycles.
- Tear-free: load 16'h1234 at cycle 5 of digit 2 → digits 2 and 3 keep old values this frame. New values appear only after frame_tick.
- Wrap collision: load 16'h00C0 in the wrap cycle → next frame shows the new value; pend_valid=0 afterwards.
- Leading zeros: digits_in=16'h0005, lz_en=1 → digits 3,2,1 dark, digit 0 seg=24. digits_in=16'h0000 → digit 0 seg=01 only. lz_en=0 → all four show 01.
- DP/blank and mid-frame reset: dp_in=4'b0100, blank_in=4'b1000 → dp=0 only during digit 2, digit 3 an stays 1. Asserting reset_n=0 mid-slot → next edge returns to reset values.
